// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative multiply/divide unit with HI/LO registers, sitting
// beside the EXE-stage ALU. One shift-add multiplier and one restoring
// divider are sequenced by a four-state FSM (IDLE, MUL, DIV, FIX); the
// FIX cycle applies the sign correction and writes HI/LO.
//
// Optional feature: define MDU_EARLY_OUT_EN to let a multiply leave the
// MUL state as soon as the remaining multiplier bits are all zero.
// Divides always run the full XLEN iterations.
//
// Handshake: estart is a one-cycle request that is accepted only in IDLE.
// While busy, any EXE instruction that needs HI/LO or a new start raises
// mdu_stall (combinational), and the frozen pipeline re-presents it once
// busy falls. MTHI/MTLO writes take effect only on unstalled edges and
// never in a cycle that also accepts a start.

module pipe_mdu #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            estart,
  input  logic [1:0]      eop,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic            euse_hilo,
  input  logic            ewhi,
  input  logic            ewlo,
  input  logic [XLEN-1:0] ewdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            mdu_stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Counter value on the final iteration (counter reaches XLEN after it).
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                is_div_q, is_div_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  // Datapath temporaries
  logic [XLEN:0]       rem_shift;
  logic [XLEN:0]       rem_sub;
  logic                qbit;
  logic [XLEN-1:0]     mplier_next;
  logic [2*XLEN-1:0]   prod;
  logic                signed_op;
  logic                wr_hi, wr_lo;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

  assign busy      = (state_q != ST_IDLE);
  assign mdu_stall = busy & (estart | euse_hilo);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Next-state logic: start latch, iteration datapath, result fix-up, MTHI/MTLO.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    is_div_d    = is_div_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rem_shift   = '0;
    rem_sub     = '0;
    qbit        = 1'b0;
    mplier_next = '0;
    prod        = '0;
    signed_op   = ~eop[0];

    // A start accepted in IDLE suppresses a simultaneous HI/LO write.
    wr_hi = ewhi & ~mdu_stall & ~(estart & ~busy);
    wr_lo = ewlo & ~mdu_stall & ~(estart & ~busy);
    if (wr_hi) hi_d = ewdata;
    if (wr_lo) lo_d = ewdata;

    case (state_q)
      ST_IDLE: begin
        if (estart) begin
          cnt_d = '0;
          if (!eop[1]) begin
            state_d  = ST_MUL;
            is_div_d = 1'b0;
            mcand_d  = {{XLEN{1'b0}}, signed_op ? magnitude(ea) : ea};
            mplier_d = signed_op ? magnitude(eb) : eb;
            neg_d    = signed_op & (ea[XLEN-1] ^ eb[XLEN-1]);
            acc_d    = '0;
          end else begin
            state_d  = ST_DIV;
            is_div_d = 1'b1;
            dvd_d    = signed_op ? magnitude(ea) : ea;
            dvs_d    = signed_op ? magnitude(eb) : eb;
            rem_d    = '0;
            qneg_d   = signed_op & (ea[XLEN-1] ^ eb[XLEN-1]);
            rneg_d   = signed_op & ea[XLEN-1];
          end
        end
      end

      ST_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d     = mcand_q << 1;
        mplier_next = mplier_q >> 1;
        mplier_d    = mplier_next;
        cnt_d       = cnt_q + CNTW'(1);
`ifdef MDU_EARLY_OUT_EN
        if ((cnt_q == LAST_ITER) || (mplier_next == '0)) state_d = ST_FIX;
`else
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
`endif
      end

      ST_DIV: begin
        // Shift one dividend bit into a widened remainder so that divisors
        // with the top bit set still compare correctly.
        rem_shift = {rem_q, dvd_q[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        qbit      = (rem_shift >= {1'b0, dvs_q});
        rem_d     = qbit ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
        dvd_d     = {dvd_q[XLEN-2:0], qbit};
        cnt_d     = cnt_q + CNTW'(1);
        if (cnt_q == LAST_ITER) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (is_div_q) begin
          lo_d = qneg_q ? (~dvd_q + XLEN'(1)) : dvd_q;
          hi_d = rneg_q ? (~rem_q + XLEN'(1)) : rem_q;
        end else begin
          prod = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_pipe_mdu.sv
// Directed testbench for pipe_mdu. Inputs change on the falling edge and
// outputs are sampled #1 after it, away from the rising (active) edge.
module tb_pipe_mdu;

  logic        clock;
  logic        resetn;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        euse_hilo;
  logic        ewhi;
  logic        ewlo;
  logic [31:0] ewdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        mdu_stall;

  int pass_cnt = 0;
  int chk_cnt  = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam int BUSY_3X5 = 4;   // eb=5: top bit index 2, plus 2
  localparam int BUSY_7X6 = 4;   // eb=6: top bit index 2, plus 2
`else
  localparam int BUSY_3X5 = 33;
  localparam int BUSY_7X6 = 33;
`endif

  pipe_mdu dut (
    .clock     (clock),
    .resetn    (resetn),
    .estart    (estart),
    .eop       (eop),
    .ea        (ea),
    .eb        (eb),
    .euse_hilo (euse_hilo),
    .ewhi      (ewhi),
    .ewlo      (ewlo),
    .ewdata    (ewdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .mdu_stall (mdu_stall)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver: present a one-cycle start, returning on the falling edge after
  // the accepting rising edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    estart = 1'b1;
    eop    = op;
    ea     = a;
    eb     = b;
    @(negedge clock);
    estart = 1'b0;
    #1;
  endtask

  // Wait (bounded) for busy to fall; returns the number of busy samples seen.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      @(negedge clock);
      #1;
      cycles++;
    end
    if (busy) begin
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, cycles);
    end else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", busy); else pass_cnt++;
    chk_cnt++;
    if (mdu_stall !== 1'b0) $display("FAIL reset_stall: got %0b required 0", mdu_stall); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h0) $display("FAIL reset_hi: got %h required 00000000", hi); else pass_cnt++;
    chk_cnt++;
    if (lo !== 32'h0) $display("FAIL reset_lo: got %h required 00000000", lo); else pass_cnt++;
    chk_cnt++;
    resetn = 1'b1;
  endtask

  task automatic test_multu();
    int n;
    start_op(2'b01, 32'd3, 32'd5);
    // First sample after the accepting edge counts as busy cycle 1.
    n = 1;
    if (busy !== 1'b1) $display("FAIL multu_busy_start: got %0b required 1", busy); else pass_cnt++;
    chk_cnt++;
    while (busy && n < 200) begin
      @(negedge clock);
      #1;
      if (busy) n++;
    end
    if (n !== BUSY_3X5) $display("FAIL multu_latency: got %0d busy cycles required %0d", n, BUSY_3X5); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h0) $display("FAIL multu_hi: got %h required 00000000", hi); else pass_cnt++;
    chk_cnt++;
    if (lo !== 32'h0000000F) $display("FAIL multu_lo: got %h required 0000000f", lo); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_mult();
    int n;
    start_op(2'b00, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h required ffffffff", hi); else pass_cnt++;
    chk_cnt++;
    if (lo !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h required fffffffa", lo); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_div();
    int n;
    start_op(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    if (n !== 33) $display("FAIL div_latency: got %0d required 33", n); else pass_cnt++;
    chk_cnt++;
    if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h required fffffffd", lo); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h required ffffffff", hi); else pass_cnt++;
    chk_cnt++;
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h required 80000000", lo); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h0) $display("FAIL div_ovf_hi: got %h required 00000000", hi); else pass_cnt++;
    chk_cnt++;
    // Unsigned divide by a divisor with the top bit set.
    start_op(2'b11, 32'hF0000005, 32'h80000001);
    wait_idle(n);
    if (lo !== 32'h1) $display("FAIL divu_big_lo: got %h required 00000001", lo); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h70000004) $display("FAIL divu_big_hi: got %h required 70000004", hi); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_divu_zero();
    int n;
    start_op(2'b11, 32'h00001234, 32'h0);
    wait_idle(n);
    if (lo !== 32'hFFFFFFFF) $display("FAIL divu0_lo: got %h required ffffffff", lo); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h00001234) $display("FAIL divu0_hi: got %h required 00001234", hi); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_stall_mflo();
    int n;
    start_op(2'b01, 32'd7, 32'd6);
    euse_hilo = 1'b1;
    #1;
    n = 0;
    while (mdu_stall && n < 200) begin
      n++;
      @(negedge clock);
      #1;
    end
    if (n !== BUSY_7X6) $display("FAIL mflo_stall_cycles: got %0d required %0d", n, BUSY_7X6); else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL mflo_busy_after: got %0b required 0", busy); else pass_cnt++;
    chk_cnt++;
    if (lo !== 32'd42) $display("FAIL mflo_lo: got %h required 0000002a", lo); else pass_cnt++;
    chk_cnt++;
    euse_hilo = 1'b0;
  endtask

  task automatic test_mtlo_busy();
    int n;
    start_op(2'b01, 32'd3, 32'd5);
    euse_hilo = 1'b1;
    ewlo      = 1'b1;
    ewdata    = 32'h000000AA;
    #1;
    n = 0;
    while (mdu_stall && n < 200) begin
      if (lo === 32'h000000AA) $display("FAIL mtlo_early: lo=%h while stalled, required not 000000aa", lo);
      n++;
      @(negedge clock);
      #1;
    end
    if (lo !== 32'h0000000F) $display("FAIL mtlo_pre: got %h required 0000000f", lo); else pass_cnt++;
    chk_cnt++;
    @(negedge clock);
    #1;
    if (lo !== 32'h000000AA) $display("FAIL mtlo_write: got %h required 000000aa", lo); else pass_cnt++;
    chk_cnt++;
    euse_hilo = 1'b0;
    ewlo      = 1'b0;
  endtask

  task automatic test_mthi_idle();
    @(negedge clock);
    ewhi   = 1'b1;
    ewdata = 32'hDEADBEEF;
    @(negedge clock);
    ewhi = 1'b0;
    #1;
    if (hi !== 32'hDEADBEEF) $display("FAIL mthi_idle: got %h required deadbeef", hi); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_start_vs_write();
    int n;
    // lo holds 000000aa here; a write issued alongside a start must be dropped.
    @(negedge clock);
    estart = 1'b1;
    eop    = 2'b01;
    ea     = 32'd2;
    eb     = 32'd2;
    ewlo   = 1'b1;
    ewdata = 32'h00000055;
    @(negedge clock);
    estart = 1'b0;
    ewlo   = 1'b0;
    #1;
    if (lo !== 32'h000000AA) $display("FAIL start_prio_lo: got %h required 000000aa", lo); else pass_cnt++;
    chk_cnt++;
    wait_idle(n);
    if (lo !== 32'd4) $display("FAIL start_prio_result: got %h required 00000004", lo); else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    start_op(2'b10, 32'd100, 32'd7);
    repeat (10) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    #1;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %0b required 0", busy); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h0) $display("FAIL rst_mid_hi: got %h required 00000000", hi); else pass_cnt++;
    chk_cnt++;
    if (lo !== 32'h0) $display("FAIL rst_mid_lo: got %h required 00000000", lo); else pass_cnt++;
    chk_cnt++;
    resetn = 1'b1;
    start_op(2'b01, 32'd2, 32'd2);
    wait_idle(n);
    if (lo !== 32'd4) $display("FAIL rst_mid_mult_lo: got %h required 00000004", lo); else pass_cnt++;
    chk_cnt++;
    if (hi !== 32'h0) $display("FAIL rst_mid_mult_hi: got %h required 00000000", hi); else pass_cnt++;
    chk_cnt++;
  endtask

  initial begin
    resetn    = 1'b0;
    estart    = 1'b0;
    eop       = 2'b00;
    ea        = 32'h0;
    eb        = 32'h0;
    euse_hilo = 1'b0;
    ewhi      = 1'b0;
    ewlo      = 1'b0;
    ewdata    = 32'h0;

    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_divu_zero();
    test_stall_mflo();
    test_mtlo_busy();
    test_mthi_idle();
    test_start_vs_write();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
